// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the MAC datapath and its
// operand sequencer.
//   seq_state_t        - sequencer FSM states
//   A_WIDTH / B_WIDTH  - default signed operand widths
//   OUT_WIDTH          - default MAC accumulator width
//   MAC_RESULT_LATENCY - cycles from the eof beat to a final MAC result
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int A_WIDTH            = 8;
  localparam int B_WIDTH            = 8;
  // Full product width plus headroom for summing 16 products.
  localparam int OUT_WIDTH          = A_WIDTH + B_WIDTH + 4;
  localparam int MAC_RESULT_LATENCY = 4;

endpackage

// File: rtl/mac_operand_buf.sv
// mac_operand_buf: DEPTH x WIDTH register array holding one frame of
// operand pairs. One synchronous write port, one combinational read port,
// no reset (contents survive a sequencer reset).
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address; addresses >= DEPTH are dropped
//   wr_data  in   packed {a, b} pair to store
//   rd_addr  in   read address
//   rd_data  out  packed {a, b} pair at rd_addr (combinational)
module mac_operand_buf #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams one buffered frame of signed operand pairs
// into the pipelined MAC, marks the last pair with eof, waits out the MAC
// latency and pulses done when the accumulated result is final.
//   clk, reset          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_a/wr_b  host write port into the operand buffer
//   start, frame_len    begin a frame of frame_len pairs
//   hold                downstream stall; freezes the whole sequencer
//   a, b, valid_in, eof operand stream to the MAC (registered)
//   enable              MAC clock enable (~hold)
//   busy                frame in progress (RUN or DRAIN)
//   done                one-cycle pulse: MAC result is final
//   err                 one-cycle pulse: start rejected (bad frame_len)
module mac_operand_sequencer #(
  parameter int A_WIDTH        = mac_pkg::A_WIDTH,
  parameter int B_WIDTH        = mac_pkg::B_WIDTH,
  parameter int DEPTH          = 16,
  parameter int RESULT_LATENCY = mac_pkg::MAC_RESULT_LATENCY,
  parameter int LEN_W          = $clog2(DEPTH + 1),
  parameter int ADDR_W         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [A_WIDTH-1:0] wr_a,
  input  logic [B_WIDTH-1:0] wr_b,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               hold,
  output logic [A_WIDTH-1:0] a,
  output logic [B_WIDTH-1:0] b,
  output logic               valid_in,
  output logic               eof,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               err
);

  import mac_pkg::*;

  localparam int PAIR_W = A_WIDTH + B_WIDTH;
  // The drain counter only ever holds RESULT_LATENCY-1 .. 0.
  localparam int CNT_W  = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RESULT_LATENCY - 1);

  seq_state_t       state_reg;
  logic [LEN_W-1:0] idx_reg;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic              wr_ok;
  logic              len_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [PAIR_W-1:0] rd_data;
  logic [PAIR_W-1:0] pair;
  logic [LEN_W-1:0]  idx_next;

  // The buffer is locked outside IDLE and frozen together with the FSM.
  assign wr_ok = wr_en && !reset && !hold && (state_reg == IDLE);

  mac_operand_buf #(
    .WIDTH  (PAIR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data ({wr_a, wr_b}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // In IDLE the only read that matters is entry 0 for the first beat.
  assign rd_addr = (state_reg == IDLE) ? '0 : idx_reg[ADDR_W-1:0];

  // A write to entry 0 in the same cycle as start must reach the first
  // beat, so forward the write data past the array.
  assign pair = (wr_ok && (wr_addr == '0)) ? {wr_a, wr_b} : rd_data;

  assign len_ok   = (frame_len != '0) && (frame_len <= DEPTH_L);
  assign idx_next = idx_reg + LEN_W'(1);
  assign enable   = ~hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      a         <= '0;
      b         <= '0;
      valid_in  <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (!hold) begin
      case (state_reg)
        IDLE: begin
          a        <= '0;
          b        <= '0;
          valid_in <= 1'b0;
          eof      <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
          if (start) begin
            if (len_ok) begin
              // Beat 1 goes out on this edge; idx counts beats issued.
              state_reg <= RUN;
              len_reg   <= frame_len;
              idx_reg   <= LEN_W'(1);
              a         <= pair[PAIR_W-1:B_WIDTH];
              b         <= pair[B_WIDTH-1:0];
              valid_in  <= 1'b1;
              eof       <= (frame_len == LEN_W'(1));
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        RUN: begin
          if (idx_reg == len_reg) begin
            // The eof beat has just been consumed.
            state_reg <= DRAIN;
            a         <= '0;
            b         <= '0;
            valid_in  <= 1'b0;
            eof       <= 1'b0;
            cnt_reg   <= DRAIN_LOAD;
            done      <= (RESULT_LATENCY == 1);
          end else begin
            idx_reg <= idx_next;
            a       <= pair[PAIR_W-1:B_WIDTH];
            b       <= pair[B_WIDTH-1:0];
            eof     <= (idx_next == len_reg);
          end
        end

        DRAIN: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            done    <= (cnt_reg == CNT_W'(1));
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed and random stimulus for the operand
// sequencer, checked cycle by cycle against a frame-level reference model
// (a queue of expected output cycles built when a frame is accepted) plus a
// behavioural MAC accumulator fed from the DUT's operand stream.
module tb_mac_operand_sequencer;

  localparam int DEPTH = 16;
  localparam int LAT   = 4;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, hold;
  logic [3:0] wr_addr;
  logic [7:0] wr_a, wr_b;
  logic [4:0] frame_len;
  logic [7:0] a, b;
  logic       valid_in, eof, enable, busy, done, err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       valid;
    logic       eof;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t        cur;
  exp_t        q[$];
  logic [15:0] mem_m [DEPTH];
  int          acc      = 0;
  int          last_sum = 0;
  int          exp_sum  = 0;

  always #5 clk = ~clk;

  mac_operand_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .start     (start),
    .frame_len (frame_len),
    .hold      (hold),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .eof       (eof),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Accept a frame in the model: every output cycle of the frame is queued.
  task automatic model_start(input int len);
    exp_t e;
    exp_sum = 0;
    for (int k = 0; k < len; k++) begin
      e       = '0;
      e.a     = mem_m[k][15:8];
      e.b     = mem_m[k][7:0];
      e.valid = 1'b1;
      e.eof   = (k == len - 1);
      e.busy  = 1'b1;
      q.push_back(e);
      exp_sum += int'($signed(e.a)) * int'($signed(e.b));
    end
    for (int d = 1; d <= LAT; d++) begin
      e      = '0;
      e.busy = 1'b1;
      e.done = (d == LAT);
      q.push_back(e);
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check outputs.
  task automatic cycle(input logic rst, input logic hld, input logic st,
                       input logic [4:0] len, input logic we,
                       input logic [3:0] addr, input logic [7:0] wa,
                       input logic [7:0] wb);
    reset = rst; hold = hld; start = st; frame_len = len;
    wr_en = we; wr_addr = addr; wr_a = wa; wr_b = wb;

    // Behavioural MAC: consumes the presented beat when not stalled.
    if (rst) begin
      acc = 0;
    end else if (!hld && valid_in === 1'b1) begin
      acc += int'($signed(a)) * int'($signed(b));
      if (eof === 1'b1) begin
        last_sum = acc;
        acc      = 0;
      end
    end

    @(posedge clk);

    if (rst) begin
      q.delete();
      cur = '0;
    end else if (!hld) begin
      if (cur.busy) begin
        if (q.size() > 0) cur = q.pop_front();
        else cur = '0;
      end else begin
        cur = '0;
        if (we) mem_m[addr] = {wa, wb};
        if (st) begin
          if (len >= 1 && len <= DEPTH) begin
            model_start(int'(len));
            cur = q.pop_front();
          end else begin
            cur.err = 1'b1;
          end
        end
      end
    end

    #1;
    $display("t=%0t rst=%0b hold=%0b start=%0b len=%0d we=%0b | a=%0d b=%0d v=%0b eof=%0b busy=%0b done=%0b err=%0b",
             $time, rst, hld, st, len, we, $signed(a), $signed(b), valid_in, eof, busy, done, err);
    chk("a",        a,        cur.a);
    chk("b",        b,        cur.b);
    chk("valid_in", valid_in, cur.valid);
    chk("eof",      eof,      cur.eof);
    chk("busy",     busy,     cur.busy);
    chk("done",     done,     cur.done);
    chk("err",      err,      cur.err);
    chk("enable",   enable,   !hld);
    if (cur.done && !rst) chk("mac_result", last_sum, exp_sum);

    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 8'd0, 8'd0);
  endtask

  task automatic go(input logic [4:0] len);
    cycle(1'b0, 1'b0, 1'b1, len, 1'b0, 4'd0, 8'd0, 8'd0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; start = 1'b0; frame_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    cur = '0;
    @(negedge clk);

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 8'd0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 8'd0, 8'd0);

    // Load a=b=i at addr i-1 for i=1..15, random pair in the last entry.
    for (int i = 1; i <= 15; i++)
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'(i - 1), 8'(i), 8'(i));
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd15, 8'($urandom), 8'($urandom));

    // Full 15-beat frame; MAC result must be 1240.
    go(5'd15);
    idle(22);
    chk("frame15_sum", last_sum, 1240);

    // Same frame with 3 held cycles mid-RUN and 2 in DRAIN.
    go(5'd15);
    for (int t = 0; t < 30; t++)
      cycle(1'b0, (t >= 4 && t <= 6) || t == 19 || t == 20, 1'b0, 5'd0,
            1'b0, 4'd0, 8'd0, 8'd0);

    // Bad lengths.
    go(5'd0);
    idle(2);
    go(5'd17);
    idle(2);

    // Locked buffer: write during RUN is ignored.
    go(5'd3);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 8'hFB, 8'hFB);
    idle(8);
    go(5'd1);
    idle(6);

    // Reset on beat 7 aborts the frame.
    go(5'd15);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 8'd0, 8'd0);
    go(5'd2);
    idle(8);

    // Single-entry frames back to back: start held high continuously.
    for (int i = 0; i < 20; i++) go(5'd1);
    idle(2);

    // Write and start in the same cycle: frame sees the new entry 0.
    cycle(1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 4'd0, 8'($urandom), 8'($urandom));
    idle(8);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 80) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, 5'($urandom_range(0, 17)),
            $urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom), 8'($urandom));
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Upstream feeder for the pipelined `mac` core. The block holds one frame of signed operand pairs in a small local buffer loaded by a host write port. On `start` it streams the pairs to the MAC as `a`/`b`/`valid_in`, marks the last pair with `eof`, and then waits out the MAC pipeline latency. It pulses `done` in the cycle the MAC's accumulated `result` is final. It also drives the MAC `enable` and applies downstream `hold` back-pressure.

## Interface
- `A_WIDTH`, 8, width of operand a (signed)
- `B_WIDTH`, 8, width of operand b (signed)
- `DEPTH`, 16, buffer entries, i.e. maximum frame length
- `RESULT_LATENCY`, 4, cycles from the eof beat on the outputs to the MAC result being final
- `LEN_W`, `$clog2(DEPTH+1)`, width of `frame_len`
- `ADDR_W`, `$clog2(DEPTH)`, width of `wr_addr`
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_a`  in  A_WIDTH  operand a to store
- `wr_b`  in  B_WIDTH  operand b to store
- `start`  in  1  begin a frame
- `frame_len`  in  LEN_W  number of pairs in the frame; sampled with `start`
- `hold`  in  1  downstream stall
- `a`  out  A_WIDTH  to MAC operand a
- `b`  out  B_WIDTH  to MAC operand b
- `valid_in`  out  1  to MAC sample valid
- `eof`  out  1  to MAC last sample of frame
- `enable`  out  1  to MAC clock enable; always equals `~hold`
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse; MAC result is final
- `err`  out  1  one-cycle pulse; `start` was rejected

## Operation
- The FSM has three states: IDLE, RUN and DRAIN. Reset forces IDLE.
- Reset values of the registered outputs: `a`=0, `b`=0, `valid_in`=0, `eof`=0, `busy`=0, `done`=0, `err`=0.
- Reset does not clear the buffer contents.
- **IDLE:**
  - `wr_en` writes {`wr_a`, `wr_b`} to entry `wr_addr`. Writes to addresses ≥ DEPTH are dropped.
  - A `start` with 1 ≤ `frame_len` ≤ DEPTH latches the length, sets read index 0 and moves to RUN.
  - A `start` with `frame_len`=0 or `frame_len` > DEPTH pulses `err` for one cycle and stays in IDLE.
- **RUN:**
  - Each non-held cycle presents entry[idx] on `a`/`b` with `valid_in`=1 and increments idx.
  - `eof`=1 only on the beat where idx = len−1.
  - After that beat the FSM moves to DRAIN.
- **DRAIN:**
  - `valid_in`=0, `eof`=0, `a`=`b`=0.
  - A down-counter loads RESULT_LATENCY−1 and decrements on non-held cycles.
  - When the counter reaches 0, `done` pulses and the FSM returns to IDLE.
- `busy`=1 in RUN and DRAIN, including the `done` cycle.
- While `busy`=1:
  - `wr_en` is ignored; the buffer is locked.
  - `start` is ignored; `err` is not pulsed.
- **hold:**
  - `hold`=1 freezes every register: FSM state, idx, drain counter and all outputs, including a pending `done`/`err` level.
  - While held, `enable`=0, so the MAC freezes in step with the sequencer.
- `wr_en` and `start` in the same cycle: the write happens first, and the frame sees the new data.
- Reset in RUN or DRAIN aborts the frame: IDLE next cycle, outputs at their reset values, no `done`.

## Timing
- Reference cycle: `start` is sampled at edge E0. Counted cycles exclude held cycles.
- Beat k (k=1..len) is on the outputs in the cycle after edge E(k−1).
- The eof beat is cycle c, which follows edge E(len−1).
- DRAIN covers cycles c+1 .. c+RESULT_LATENCY.
- `done`=1 during cycle c+RESULT_LATENCY.
- The first cycle where IDLE accepts a new `start` is c+RESULT_LATENCY+1, so `done` → `start` gives back-to-back frames with no dead cycle.
- `err` is asserted in the cycle after the bad `start`.
- The read path is combinational from the register array into the output registers, so there is no extra latency.

## Structure
- Package `mac_pkg`:
  - `seq_state_t` enum (IDLE, RUN, DRAIN)
  - default widths `A_WIDTH`/`B_WIDTH`/`OUT_WIDTH`
  - `MAC_RESULT_LATENCY`=4, shared with the MAC bench
- Natural sub-module `mac_operand_buf`:
  - DEPTH × (A_WIDTH+B_WIDTH) register array
  - one synchronous write port, one combinational read port
  - no reset
- The top level holds the FSM, the counters and the output registers.

## Test plan
- **Full frame into MAC:** load a=b=i at addr i−1 for i=1..15, `start` with `frame_len`=15 → 15 `valid_in` beats, `eof` only on beat 15, `done` 4 cycles after the eof beat, MAC `result`=1240.
- **Hold:** same frame with `hold` high for 3 cycles mid-RUN and 2 cycles in DRAIN → identical beat sequence, `done` delayed by exactly 5 cycles, `enable`=0 exactly during the hold cycles.
- **Bad length:** `start` with `frame_len`=0, then with 17 → `err` pulses once each, `busy` stays 0, no `valid_in`.
- **Locked buffer:** `wr_en` to addr 0 with a=−5 during RUN → ignored; a rerun of `frame_len`=1 outputs the original a=1, b=1.
- **Reset mid-frame:** `reset` on beat 7 → next cycle all outputs 0 and `busy`=0, no `done`; a fresh start with `frame_len`=2 outputs (1,1),(2,2) with `eof` on beat 2.
- **Single-entry and back-to-back frames:** `frame_len`=1 → `valid_in` and `eof` in the same cycle, `done` 4 cycles later; `start` asserted in the cycle after `done` → accepted, first beat appears one cycle later.
